// File: rtl/map_seg_pkg.sv
// Shared types, width helpers and reset-map constant for the segment-header ring.
package map_seg_pkg;

  localparam int unsigned DEF_NUM_LREG = 16;
  localparam int unsigned DEF_PTAG_W   = 6;
  localparam int unsigned ENT_W        = DEF_PTAG_W + 1;
  localparam int unsigned MAP_W        = DEF_NUM_LREG * ENT_W;
  // Upper bound on map width the identity helper can build.
  localparam int unsigned MAX_MAP_W    = 4096;

  typedef struct packed {
    logic                  vld;
    logic [DEF_PTAG_W-1:0] tag;
  } map_ent_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_e;

  // Map entry width: valid bit plus physical tag.
  function automatic int unsigned ent_w(input int unsigned ptag_w);
    return ptag_w + 1;
  endfunction

  // Full map width for num_lreg entries.
  function automatic int unsigned map_w(input int unsigned num_lreg, input int unsigned ptag_w);
    return num_lreg * (ptag_w + 1);
  endfunction

  // Identity map: entry l = {1'b1, l}; caller truncates to its own map width.
  function automatic logic [MAX_MAP_W-1:0] identity_map(input int unsigned num_lreg,
                                                        input int unsigned ptag_w);
    logic [MAX_MAP_W-1:0] m;
    m = '0;
    for (int unsigned l = 0; l < num_lreg; l++) begin
      m = m | (MAX_MAP_W'((32'd1 << ptag_w) | l) << (l * (ptag_w + 1)));
    end
    return m;
  endfunction

endpackage

// File: rtl/map_free_drain.sv
// Captures the retired segment's header, builds the kill mask and streams
// overwritten physical tags to the free list, lowest logical register first.
module map_free_drain
  import map_seg_pkg::*;
#(
  parameter int unsigned NUM_LREG = 16,
  parameter int unsigned PTAG_W   = 6,
  localparam int unsigned ENT_BITS = ent_w(PTAG_W),
  localparam int unsigned MAP_BITS = map_w(NUM_LREG, PTAG_W),
  localparam int unsigned TAGS_W   = NUM_LREG * PTAG_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rtr_vld,
  input  logic [MAP_BITS-1:0] old_map,
  input  logic [TAGS_W-1:0]   new_tags,
  output logic                rtr_rdy,
  output logic                fre_vld,
  output logic [PTAG_W-1:0]   fre_tag,
  input  logic                fre_rdy
);

  drain_state_e          state_q, state_d;
  logic [TAGS_W-1:0]     old_tag_q, old_tag_d;
  logic [NUM_LREG-1:0]   kill_q, kill_d;
  logic [TAGS_W-1:0]     old_tags_c;
  logic [NUM_LREG-1:0]   kill_new_c;
  logic [NUM_LREG-1:0]   pick_c;
  logic [PTAG_W-1:0]     pick_tag_c;
  logic [PTAG_W-1:0]     tag_or [NUM_LREG+1];

  // Isolate the lowest pending kill bit.
  assign pick_c = kill_q & (~kill_q + NUM_LREG'(1));

  assign tag_or[0]  = '0;
  assign pick_tag_c = tag_or[NUM_LREG];

  // Per-register kill detection and one-hot tag select.
  for (genvar l = 0; l < NUM_LREG; l++) begin : g_lreg
    assign old_tags_c[l*PTAG_W +: PTAG_W] = old_map[l*ENT_BITS +: PTAG_W];
    assign kill_new_c[l] = old_map[l*ENT_BITS + PTAG_W] &
                           (old_map[l*ENT_BITS +: PTAG_W] != new_tags[l*PTAG_W +: PTAG_W]);
    assign tag_or[l+1]   = tag_or[l] |
                           ({PTAG_W{pick_c[l]}} & old_tag_q[l*PTAG_W +: PTAG_W]);
  end

  // Drain FSM next state, capture and handshake outputs.
  always_comb begin
    state_d   = state_q;
    old_tag_d = old_tag_q;
    kill_d    = kill_q;
    rtr_rdy   = 1'b0;
    fre_vld   = 1'b0;
    fre_tag   = '0;
    case (state_q)
      ST_IDLE: begin
        rtr_rdy = 1'b1;
        if (rtr_vld) begin
          old_tag_d = old_tags_c;
          kill_d    = kill_new_c;
          if (|kill_new_c) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        fre_vld = 1'b1;
        fre_tag = pick_tag_c;
        if (fre_rdy) begin
          kill_d = kill_q & ~pick_c;
          if (kill_d == '0) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      old_tag_q <= '0;
      kill_q    <= '0;
    end else begin
      state_q   <= state_d;
      old_tag_q <= old_tag_d;
      kill_q    <= kill_d;
    end
  end

endmodule

// File: rtl/map_seg_ring.sv
// Segment-header ring: one header map per segment, oldest-segment pointer and
// per-segment base-map selection. Tag draining on retire is built only when
// SEG_RTR_FREE_EN is defined; otherwise retire is always ready and frees nothing.
module map_seg_ring
  import map_seg_pkg::*;
#(
  parameter int unsigned NUM_SEG  = 2,
  parameter int unsigned NUM_LREG = 16,
  parameter int unsigned PTAG_W   = 6,
  localparam int unsigned MAP_BITS = map_w(NUM_LREG, PTAG_W),
  localparam int unsigned SEG_W    = $clog2(NUM_SEG)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SEG*MAP_BITS-1:0] seg_end_map_flat,
  output logic [NUM_SEG*MAP_BITS-1:0] seg_base_map_flat,
  output logic [MAP_BITS-1:0]         arch_map,
  output logic [SEG_W-1:0]            oldest_seg,
  input  logic                        rtr_vld,
  output logic                        rtr_rdy,
  output logic                        fre_vld,
  output logic [PTAG_W-1:0]           fre_tag,
  input  logic                        fre_rdy
);

  localparam logic [MAP_BITS-1:0] ID_MAP = MAP_BITS'(identity_map(NUM_LREG, PTAG_W));

  logic [MAP_BITS-1:0] end_map [NUM_SEG];
  logic [MAP_BITS-1:0] hdr_q   [NUM_SEG];
  logic [MAP_BITS-1:0] hdr_d   [NUM_SEG];
  logic [SEG_W-1:0]    oldest_q, oldest_d;
  logic [SEG_W-1:0]    nxt_seg_c;
  logic                rtr_fire_c;

  // Unpack end maps and select each segment's base map.
  for (genvar s = 0; s < NUM_SEG; s++) begin : g_seg
    localparam int unsigned PREV = (s + NUM_SEG - 1) % NUM_SEG;
    assign end_map[s] = seg_end_map_flat[s*MAP_BITS +: MAP_BITS];
    assign seg_base_map_flat[s*MAP_BITS +: MAP_BITS] =
      (oldest_q == SEG_W'(s)) ? hdr_q[s] : end_map[PREV];
  end

  assign nxt_seg_c  = oldest_q + SEG_W'(1);
  assign arch_map   = hdr_q[oldest_q];
  assign oldest_seg = oldest_q;
  assign rtr_fire_c = rtr_vld & rtr_rdy;

  // Retire loads the next segment's header and advances the oldest pointer.
  always_comb begin
    hdr_d    = hdr_q;
    oldest_d = oldest_q;
    if (rtr_fire_c) begin
      hdr_d[nxt_seg_c] = end_map[oldest_q];
      oldest_d         = nxt_seg_c;
    end
  end

  // Header array and oldest pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SEG; s++) hdr_q[s] <= ID_MAP;
      oldest_q <= '0;
    end else begin
      hdr_q    <= hdr_d;
      oldest_q <= oldest_d;
    end
  end

`ifdef SEG_RTR_FREE_EN
  localparam int unsigned ENT_BITS = ent_w(PTAG_W);

  logic [NUM_LREG*PTAG_W-1:0] new_tags_c;

  // Tags of the retiring segment's end map, compared against its header.
  for (genvar l = 0; l < NUM_LREG; l++) begin : g_new_tag
    assign new_tags_c[l*PTAG_W +: PTAG_W] = end_map[oldest_q][l*ENT_BITS +: PTAG_W];
  end

  map_free_drain #(
    .NUM_LREG (NUM_LREG),
    .PTAG_W   (PTAG_W)
  ) u_drain (
    .clk      (clk),
    .rst      (rst),
    .rtr_vld  (rtr_vld),
    .old_map  (arch_map),
    .new_tags (new_tags_c),
    .rtr_rdy  (rtr_rdy),
    .fre_vld  (fre_vld),
    .fre_tag  (fre_tag),
    .fre_rdy  (fre_rdy)
  );
`else
  logic unused_fre_rdy;

  assign rtr_rdy        = 1'b1;
  assign fre_vld        = 1'b0;
  assign fre_tag        = '0;
  assign unused_fre_rdy = fre_rdy;
`endif

endmodule

// File: doc/map_seg_ring.md
# map_seg_ring

Segment-header ring for the rename/tag unit. It generalises the two-header scheme to NUM_SEG segments, each carrying a logical-to-physical map. It keeps one header map per segment and a pointer to the oldest (architectural) segment, and supplies every segment's base map: the header for the oldest segment, the previous segment's end map for all others. On segment retirement it advances the ring, then drains the physical tags that the retired segment overwrote to the free list over a valid/ready stream.

## Interface
Parameters:
- NUM_SEG, 2: number of segments; power of two, ≥2.
- NUM_LREG, 16: logical registers per map.
- PTAG_W, 6: physical tag width. Map entry = {vld, tag}, so ENT_W = PTAG_W+1 and MAP_W = NUM_LREG*ENT_W.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- seg_end_map_flat  in  NUM_SEG*MAP_W  end map of segment s at bits [MAP_W*(s+1)-1 : MAP_W*s]; entry l at [ENT_W*(l+1)-1 : ENT_W*l].
- seg_base_map_flat  out  NUM_SEG*MAP_W  base map per segment, same packing.
- arch_map  out  MAP_W  header of the oldest segment.
- oldest_seg  out  log2(NUM_SEG)  index of the architectural segment.
- rtr_vld  in  1  request to retire the oldest segment.
- rtr_rdy  out  1  retire accepted when rtr_vld & rtr_rdy.
- fre_vld  out  1  a freed tag is presented.
- fre_tag  out  PTAG_W  the freed physical tag.
- fre_rdy  in  1  free list accepts fre_tag.

## Operation
- Base maps are combinational:
  - seg_base_map[s] = hdr[s] when s == oldest_seg.
  - Otherwise seg_base_map[s] = seg_end_map[(s-1) mod NUM_SEG].
- Retire accept, with o = oldest_seg:
  - hdr[(o+1) mod N] <= seg_end_map[o].
  - oldest_seg <= (o+1) mod N, wrapping from N-1 to 0.
  - Capture old = hdr[o] and new = seg_end_map[o].
  - Capture kill mask k[l] = old[l].vld & (old[l].tag != new[l].tag).
- Drain FSM:
  - IDLE:
    - rtr_rdy = 1.
    - On accept with k ≠ 0, go to DRAIN.
    - On accept with k == 0, stay in IDLE.
  - DRAIN:
    - rtr_rdy = 0.
    - fre_vld = 1.
    - fre_tag = old[lowest set bit of k].tag.
    - On fre_rdy, clear that bit of k.
    - When the last bit is cleared, return to IDLE.
  - fre_tag holds while fre_rdy is low.
- Headers other than (o+1) are never written.
- Unused headers keep stale contents. This is harmless because they are only read as the oldest segment's header, and each is rewritten by the retire that makes it oldest.

## Timing
- Reset values:
  - Every hdr[s] = identity map, entry l = {1'b1, l}.
  - oldest_seg = 0.
  - FSM = IDLE, rtr_rdy = 1, fre_vld = 0, fre_tag = 0.
- Base maps and arch_map have zero latency from seg_end_map / register state.
- Retire accepted at edge t:
  - The new oldest_seg, arch_map and base maps are visible after edge t.
  - fre_vld rises in cycle t+1 when k ≠ 0.
- The mask holds m bits and fre_rdy is held high:
  - Tags appear on cycles t+1 … t+m.
  - rtr_rdy is high again in cycle t+m+1.
- rtr_vld while rtr_rdy = 0 is ignored. There is no queuing, and the requester must hold rtr_vld.
- Tags leave in ascending logical-register order.
- Reset mid-drain discards remaining freed tags and restores all reset values.

## Configuration
- SEG_RTR_FREE_EN:
  - Defined: the drain FSM and kill-mask logic are present, as described above.
  - Undefined: no drain logic. rtr_rdy is tied 1, fre_vld is tied 0 and fre_tag is tied 0. Retire still advances the ring and writes the header; fre_rdy is unused.

## Structure
- Shared package map_seg_pkg holds:
  - ENT_W and MAP_W localparam derivations.
  - A map-entry typedef {vld, tag}.
  - An identity-map constant function parametrised by NUM_LREG and PTAG_W.
- One sub-module, map_free_drain, holds the capture registers, kill mask, priority pick and FSM. It is instantiated only under SEG_RTR_FREE_EN.
- The top level holds the header array, oldest pointer and base-map muxing.

## Test plan
- Reset, NUM_SEG=4:
  - oldest_seg = 0.
  - arch_map is the identity map.
  - seg_base_map[1] = seg_end_map[0] and seg_base_map[0] = hdr[0].
  - fre_vld = 0 and rtr_rdy = 1.
- Retire where end map 0 remaps l3→20, l7→21, l9→22:
  - hdr[1] loads end map 0 and oldest_seg becomes 1.
  - Freed tags 3, 7, 9 appear on three consecutive cycles with fre_rdy held high.
  - rtr_rdy returns on the 4th cycle.
- Same retire with fre_rdy low for 2 cycles on tag 7: tag 7 is held stable and no tag is skipped or duplicated.
- Retire with end map equal to the header: no fre_vld pulse, and rtr_rdy stays high for back-to-back retires.
- rtr_vld high during DRAIN: oldest_seg is unchanged until rtr_rdy rises, then the retire is accepted once.
- Four retires with NUM_SEG=4: oldest_seg goes 1, 2, 3, 0. Then assert rst mid-drain: fre_vld = 0 next cycle and all headers are the identity map.
